llc_cmd_scheduler: RTL

LLC_CMD_SCHEDULER -- requirements
Module: llc_cmd_scheduler

---
 rtl/llc_cmd_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/llc_cmd_scheduler.sv
// Arbitrates snoop/L1D/L1I requests into a single-outstanding LLC command stream.
// Snoop has fixed priority; L1D and L1I share the remaining slots round-robin.
module llc_cmd_scheduler #(
  parameter int CMDSIZE   = 4,
  parameter int ADDR_BITS = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             req_valid,
  input  logic [3*CMDSIZE-1:0]   req_cmd,
  input  logic [3*ADDR_BITS-1:0] req_addr,
  output logic [2:0]             req_ready,
  output logic                   llc_valid,
  input  logic                   llc_ready,
  output logic [CMDSIZE-1:0]     llc_cmd,
  output logic [ADDR_BITS-1:0]   llc_addr,
  output logic [1:0]             llc_src,
  input  logic                   llc_done,
  output logic                   busy,
  output logic                   illegal_pulse,
  output logic                   timeout_err,
  output logic [15:0]            issued_cnt,
  output logic [7:0]             illegal_cnt
);

  // state    | meaning
  // ST_IDLE  | arbitrating, req_ready may fire
  // ST_ISSUE | llc_valid high, holding command until llc_ready
  // ST_WAIT  | command accepted, waiting for llc_done or timeout
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   rr_l1i_q, rr_l1i_d;
  logic [CMDSIZE-1:0]     cmd_q, cmd_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [1:0]             src_q, src_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic                   illegal_pulse_q, illegal_pulse_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [15:0]            issued_cnt_q, issued_cnt_d;
  logic [7:0]             illegal_cnt_q, illegal_cnt_d;

  logic [2:0]             grant;
  logic [1:0]             gsel;
  logic [CMDSIZE-1:0]     sel_cmd;
  logic [ADDR_BITS-1:0]   sel_addr;
  logic                   sel_legal;

  function automatic logic cmd_legal(input logic [1:0] src, input logic [CMDSIZE-1:0] cmd);
    logic ok;
    ok = 1'b0;
    case (src)
      2'd0:    ok = (cmd >= CMDSIZE'(3)) && (cmd <= CMDSIZE'(6));
      2'd1:    ok = (cmd == CMDSIZE'(0)) || (cmd == CMDSIZE'(1)) ||
                    (cmd == CMDSIZE'(8)) || (cmd == CMDSIZE'(9));
      2'd2:    ok = (cmd == CMDSIZE'(2));
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // rst_n gates the grant so req_ready reads 0 during reset even with requests pending
  always_comb begin
    grant = 3'b000;
    gsel  = 2'd0;
    if (state_q == ST_IDLE && rst_n) begin
      if (req_valid[0]) begin
        grant = 3'b001;
        gsel  = 2'd0;
      end else if (req_valid[1] && (!req_valid[2] || !rr_l1i_q)) begin
        grant = 3'b010;
        gsel  = 2'd1;
      end else if (req_valid[2]) begin
        grant = 3'b100;
        gsel  = 2'd2;
      end
    end
    sel_cmd   = req_cmd[int'(gsel)*CMDSIZE +: CMDSIZE];
    sel_addr  = req_addr[int'(gsel)*ADDR_BITS +: ADDR_BITS];
    sel_legal = cmd_legal(gsel, sel_cmd);
  end

  always_comb begin
    state_d         = state_q;
    rr_l1i_d        = rr_l1i_q;
    cmd_d           = cmd_q;
    addr_d          = addr_q;
    src_d           = src_q;
    wait_cnt_d      = wait_cnt_q;
    illegal_pulse_d = 1'b0;
    timeout_err_d   = timeout_err_q;
    issued_cnt_d    = issued_cnt_q;
    illegal_cnt_d   = illegal_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          cmd_d  = sel_cmd;
          addr_d = sel_addr;
          src_d  = gsel;
          if (gsel != 2'd0) rr_l1i_d = (gsel == 2'd1);
          if (sel_legal) begin
            state_d = ST_ISSUE;
          end else begin
            illegal_pulse_d = 1'b1;
            if (illegal_cnt_q != 8'hFF) illegal_cnt_d = illegal_cnt_q + 8'd1;
          end
        end
      end
      ST_ISSUE: begin
        if (llc_ready) begin
          state_d      = ST_WAIT;
          wait_cnt_d   = 8'd0;
          issued_cnt_d = issued_cnt_q + 16'd1;
        end
      end
      ST_WAIT: begin
        if (llc_done) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      rr_l1i_q        <= 1'b0;
      cmd_q           <= '0;
      addr_q          <= '0;
      src_q           <= 2'd0;
      wait_cnt_q      <= 8'd0;
      illegal_pulse_q <= 1'b0;
      timeout_err_q   <= 1'b0;
      issued_cnt_q    <= 16'd0;
      illegal_cnt_q   <= 8'd0;
    end else begin
      state_q         <= state_d;
      rr_l1i_q        <= rr_l1i_d;
      cmd_q           <= cmd_d;
      addr_q          <= addr_d;
      src_q           <= src_d;
      wait_cnt_q      <= wait_cnt_d;
      illegal_pulse_q <= illegal_pulse_d;
      timeout_err_q   <= timeout_err_d;
      issued_cnt_q    <= issued_cnt_d;
      illegal_cnt_q   <= illegal_cnt_d;
    end
  end

  assign req_ready     = grant;
  assign llc_valid     = (state_q == ST_ISSUE);
  assign busy          = (state_q != ST_IDLE);
  assign llc_cmd       = cmd_q;
  assign llc_addr      = addr_q;
  assign llc_src       = src_q;
  assign illegal_pulse = illegal_pulse_q;
  assign timeout_err   = timeout_err_q;
  assign issued_cnt    = issued_cnt_q;
  assign illegal_cnt   = illegal_cnt_q;

endmodule
